// File: rtl/ysyx_22041412_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_lsu_pkg
// Description : Shared LSU definitions: FSM states, request kinds, exception
//               codes and the zero-word constant.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041412_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Encoded as {is_store, is_load} so the mapping from the raw flags is direct.
  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_BOTH  = 2'd3
  } lsu_kind_e;

  localparam logic [1:0]  EXC_NONE     = 2'd0;
  localparam logic [1:0]  EXC_MISALIGN = 2'd1;
  localparam logic [1:0]  EXC_NULL     = 2'd2;
  localparam logic [1:0]  EXC_ILLEGAL  = 2'd3;

  localparam logic [63:0] ZERO_WORD    = 64'd0;

  function automatic lsu_kind_e kind_of(input logic is_load, input logic is_store);
    return lsu_kind_e'({is_store, is_load});
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041412_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_lsu_if
// Description : EX-side request, SRAM request/response and WB-side response
//               signals of the LSU. slave = LSU view, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22041412_lsu_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_is_load;
  logic                  in_is_store;
  logic [2:0]            in_func3;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic [4:0]            in_rd;

  logic                  mem_en;
  logic                  mem_wen;
  logic [2:0]            mem_func3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_stall;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_rd;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_exc;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_func3, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_en, mem_wen, mem_func3, mem_addr, mem_wdata,
    input  mem_stall, mem_rdata,
    output out_valid, out_rd, out_data, out_exc,
    input  out_ready
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_func3, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_en, mem_wen, mem_func3, mem_addr, mem_wdata,
    output mem_stall, mem_rdata,
    input  out_valid, out_rd, out_data, out_exc,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22041412_lsu_check.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_lsu_check
// Description : Combinational legality / null / alignment check of a request.
//               Priority: illegal > null address > misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041412_lsu_check
  import ysyx_22041412_lsu_pkg::*;
(
  input  lsu_kind_e  kind,
  input  logic [2:0] func3,
  input  logic [2:0] addr_lo,
  input  logic       addr_null,
  output logic [1:0] exc
);

  logic illegal;
  logic misaligned;

  // Classify the request; pass-through requests never raise an exception.
  always_comb begin
    illegal = (kind == KIND_BOTH)
           || ((kind == KIND_LOAD)  && (func3 == 3'b111))
           || ((kind == KIND_STORE) && (func3 >  3'b011));

    // Width is func3[1:0]; 3'b111 is already illegal so x11 means doubleword.
    unique case (func3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo[1:0];
      2'b11:   misaligned = ~func3[2] & (|addr_lo);
      default: misaligned = 1'b0;
    endcase

    if (kind == KIND_NONE)  exc = EXC_NONE;
    else if (illegal)       exc = EXC_ILLEGAL;
    else if (addr_null)     exc = EXC_NULL;
    else if (misaligned)    exc = EXC_MISALIGN;
    else                    exc = EXC_NONE;
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22041412_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_lsu
// Description : Single-outstanding load/store unit. IDLE accepts a request,
//               ACCESS holds a registered SRAM request until the SRAM stops
//               stalling, RESP presents the result until WB takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041412_lsu
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22041412_lsu_if.slave  bus
);

  lsu_state_e            state_q,     state_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  is_load_q,   is_load_d;
  logic                  mem_en_q,    mem_en_d;
  logic                  mem_wen_q,   mem_wen_d;
  logic [2:0]            mem_func3_q, mem_func3_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  out_valid_q, out_valid_d;
  logic [4:0]            out_rd_q,    out_rd_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]            out_exc_q,   out_exc_d;

  lsu_kind_e             kind;
  logic                  addr_null;
  logic [1:0]            exc;

  assign kind      = kind_of(bus.in_is_load, bus.in_is_store);
  assign addr_null = (bus.in_addr == '0);

  ysyx_22041412_lsu_check u_check (
    .kind      (kind),
    .func3     (bus.in_func3),
    .addr_lo   (bus.in_addr[2:0]),
    .addr_null (addr_null),
    .exc       (exc)
  );

  // Next-state and registered-output computation for the three-state FSM.
  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    mem_en_d    = mem_en_q;
    mem_wen_d   = mem_wen_q;
    mem_func3_d = mem_func3_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    out_exc_d   = out_exc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          is_load_d   = bus.in_is_load;
          mem_func3_d = bus.in_func3;
          mem_addr_d  = bus.in_addr;
          mem_wdata_d = bus.in_wdata;
          out_rd_d    = bus.in_is_store ? 5'd0 : bus.in_rd;
          out_exc_d   = exc;
          if ((kind != KIND_NONE) && (exc == EXC_NONE)) begin
            state_d   = ST_ACCESS;
            mem_en_d  = 1'b1;
            mem_wen_d = bus.in_is_store;
          end else begin
            // Pass-through or faulting request: answer without touching SRAM.
            state_d     = ST_RESP;
            out_valid_d = 1'b1;
            out_data_d  = (kind == KIND_NONE) ? DATA_WIDTH'(bus.in_addr)
                                              : DATA_WIDTH'(ZERO_WORD);
          end
        end
      end
      ST_ACCESS: begin
        if (!bus.mem_stall) begin
          state_d     = ST_RESP;
          mem_en_d    = 1'b0;
          mem_wen_d   = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = is_load_q ? bus.mem_rdata : DATA_WIDTH'(ZERO_WORD);
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      is_load_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_func3_q <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= 5'd0;
      out_data_q  <= '0;
      out_exc_q   <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      is_load_q   <= is_load_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_func3_q <= mem_func3_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      out_exc_q   <= out_exc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_func3 = mem_func3_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_exc   = out_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041412_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041412_lsu
// Description : Self-checking bench for the LSU: a 1-cycle-stall SRAM with
//               sign/zero extension, a transaction-level reference model with
//               a per-cycle compare, and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041412_lsu;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22041412_lsu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ysyx_22041412_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- SRAM environment ----------------
  function automatic logic [63:0] sram_word(input logic [63:0] a);
    case ({a[63:3], 3'b000})
      64'h0000_0000_8000_0008: return 64'h1122_3344_5566_7788;
      64'h0000_0000_8000_0000: return 64'h8001_0000_0000_8000;
      default:                 return 64'hA5A5_0000_0000_0000 ^ a;
    endcase
  endfunction

  function automatic logic [63:0] sram_read(input logic [63:0] a, input logic [2:0] f3);
    logic [63:0] w;
    w = sram_word(a) >> {a[2:0], 3'b000};
    case (f3)
      3'd0:    return {{56{w[7]}},  w[7:0]};
      3'd1:    return {{48{w[15]}}, w[15:0]};
      3'd2:    return {{32{w[31]}}, w[31:0]};
      3'd4:    return {56'd0, w[7:0]};
      3'd5:    return {48'd0, w[15:0]};
      3'd6:    return {32'd0, w[31:0]};
      default: return w;
    endcase
  endfunction

  int en_cycles = 0;
  always @(posedge clk) en_cycles <= bus.mem_en ? en_cycles + 1 : 0;
  assign bus.mem_stall = bus.mem_en && (en_cycles == 0);
  assign bus.mem_rdata = sram_read(bus.mem_addr, bus.mem_func3);

  // ---------------- reference model ----------------
  typedef struct {
    logic        mem;
    logic        store;
    logic [63:0] addr;
    logic [2:0]  f3;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [1:0]  exc;
    logic [63:0] data;
    int          ready_edge;
  } txn_t;

  function automatic txn_t predict(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [63:0] addr, input logic [63:0] wdata,
                                   input logic [4:0] rd);
    txn_t t;
    int   size;
    size = 1 << f3[1:0];
    if ((ld && st) || (ld && f3 == 3'd7) || (st && f3 > 3'd3)) t.exc = 2'd3;
    else if ((ld || st) && addr == 64'd0)                      t.exc = 2'd2;
    else if ((ld || st) && (addr % size) != 0)                 t.exc = 2'd1;
    else                                                       t.exc = 2'd0;
    t.mem   = (ld || st) && (t.exc == 2'd0);
    t.store = st;
    t.addr  = addr;
    t.f3    = f3;
    t.wdata = wdata;
    t.rd    = st ? 5'd0 : rd;
    if (!ld && !st)        t.data = addr;
    else if (t.exc != 0)   t.data = 64'd0;
    else if (ld)           t.data = sram_read(addr, f3);
    else                   t.data = 64'd0;
    t.ready_edge = 0;
    return t;
  endfunction

  txn_t cur;
  bit   pending   = 0;
  int   edge_cnt  = 0;
  int   low_edges = 0;

  // Model update at each edge: reset, handshake, or acceptance.
  always @(posedge clk) begin
    if (rst) begin
      pending   = 0;
      low_edges = 0;
    end else begin
      if (pending && edge_cnt >= cur.ready_edge && bus.out_ready) begin
        pending = 0;
      end else if (!pending && low_edges >= 1 && bus.in_valid) begin
        cur = predict(bus.in_is_load, bus.in_is_store, bus.in_func3,
                      bus.in_addr, bus.in_wdata, bus.in_rd);
        // Memory ops spend two cycles in the stalling SRAM before responding.
        cur.ready_edge = edge_cnt + 1 + (cur.mem ? 2 : 0);
        pending = 1;
      end
      low_edges++;
    end
    edge_cnt++;
  end

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      automatic bit exp_valid = pending && (edge_cnt >= cur.ready_edge);
      automatic bit exp_mem   = pending && cur.mem && (edge_cnt < cur.ready_edge);
      check("mon in_ready",  bus.in_ready,  (!pending && low_edges >= 1));
      check("mon out_valid", bus.out_valid, exp_valid);
      check("mon mem_en",    bus.mem_en,    exp_mem);
      if (exp_mem) begin
        check("mon mem_wen",   bus.mem_wen,   cur.store);
        check("mon mem_addr",  bus.mem_addr,  cur.addr);
        check("mon mem_func3", bus.mem_func3, cur.f3);
        if (cur.store) check("mon mem_wdata", bus.mem_wdata, cur.wdata);
      end
      if (exp_valid) begin
        check("mon out_rd",   bus.out_rd,   cur.rd);
        check("mon out_data", bus.out_data, cur.data);
        check("mon out_exc",  bus.out_exc,  cur.exc);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [4:0] rd, output int acc_edge);
    int guard;
    bit done;
    guard = 0;
    done  = 0;
    bus.in_valid    = 1'b1;
    bus.in_is_load  = ld;
    bus.in_is_store = st;
    bus.in_func3    = f3;
    bus.in_addr     = addr;
    bus.in_wdata    = wdata;
    bus.in_rd       = rd;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else if (++guard > 30) begin
        check("issue timeout", 1'b0, 1'b1);
        done = 1;
      end
    end
    acc_edge     = edge_cnt;
    bus.in_valid = 1'b0;
  endtask

  // Waits for the response; latency counts cycles after the accept edge.
  task automatic await_resp(input string nm, input logic [63:0] exp_data,
                            input logic [1:0] exp_exc, input logic [4:0] exp_rd,
                            input int exp_lat, input int exp_en);
    int lat, en;
    bit seen;
    lat = 0; en = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.mem_en) en++;
      if (bus.out_valid) seen = 1;
    end
    check({nm, " out_valid seen"}, seen,     1'b1);
    check({nm, " out_data"},       bus.out_data, exp_data);
    check({nm, " out_exc"},        bus.out_exc,  exp_exc);
    check({nm, " out_rd"},         bus.out_rd,   exp_rd);
    check({nm, " latency"},        lat,      exp_lat);
    check({nm, " mem_en cycles"},  en,       exp_en);
    @(posedge clk);
    #1;
  endtask

  int e1, e2;

  initial begin
    bus.in_valid = 0; bus.in_is_load = 0; bus.in_is_store = 0; bus.in_func3 = 0;
    bus.in_addr = 0;  bus.in_wdata = 0;   bus.in_rd = 0;       bus.out_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready",  bus.in_ready,  0);
    check("rst mem_en",    bus.mem_en,    0);
    check("rst mem_wen",   bus.mem_wen,   0);
    check("rst mem_addr",  bus.mem_addr,  0);
    check("rst mem_wdata", bus.mem_wdata, 0);
    check("rst mem_func3", bus.mem_func3, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_rd",    bus.out_rd,    0);
    check("rst out_data",  bus.out_data,  0);
    check("rst out_exc",   bus.out_exc,   0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    check("in_ready after release", bus.in_ready, 1);

    // Loads
    issue(1, 0, 3'd3, 64'h8000_0008, 0, 5'd5, e1);
    await_resp("ld", 64'h1122_3344_5566_7788, 2'd0, 5'd5, 3, 2);
    issue(1, 0, 3'd0, 64'h8000_0001, 0, 5'd6, e1);
    await_resp("lb", 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 5'd6, 3, 2);
    issue(1, 0, 3'd4, 64'h8000_0001, 0, 5'd6, e1);
    await_resp("lbu", 64'h0000_0000_0000_0080, 2'd0, 5'd6, 3, 2);
    issue(1, 0, 3'd1, 64'h8000_0006, 0, 5'd8, e1);
    await_resp("lh", 64'hFFFF_FFFF_FFFF_8001, 2'd0, 5'd8, 3, 2);

    // Stores and exceptions
    issue(0, 1, 3'd2, 64'h8000_0002, 64'hCAFE, 5'd7, e1);
    await_resp("sw misaligned", 64'd0, 2'd1, 5'd0, 1, 0);
    issue(0, 1, 3'd3, 64'h0, 64'h1, 5'd7, e1);
    await_resp("sd null", 64'd0, 2'd2, 5'd0, 1, 0);
    issue(0, 1, 3'd3, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 5'd9, e1);
    await_resp("sd legal", 64'd0, 2'd0, 5'd0, 3, 2);
    issue(1, 1, 3'd3, 64'h8000_0008, 0, 5'd4, e1);
    await_resp("ld+st illegal", 64'd0, 2'd3, 5'd0, 1, 0);
    issue(1, 0, 3'd7, 64'h8000_0003, 0, 5'd4, e1);
    await_resp("load f3=7 illegal", 64'd0, 2'd3, 5'd4, 1, 0);
    issue(0, 1, 3'd4, 64'h0, 0, 5'd4, e1);
    await_resp("store f3=4 at null", 64'd0, 2'd3, 5'd0, 1, 0);
    issue(1, 0, 3'd2, 64'h8000_0006, 0, 5'd4, e1);
    await_resp("lw misaligned", 64'd0, 2'd1, 5'd4, 1, 0);

    // Pass-through held by WB back-pressure
    bus.out_ready = 0;
    issue(0, 0, 3'd0, 64'h1234, 0, 5'd3, e1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_valid", bus.out_valid, 1);
      check("hold out_data",  bus.out_data,  64'h1234);
      check("hold in_ready",  bus.in_ready,  0);
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    check("hold released", bus.out_valid, 0);

    // Issue interval: pass-through then memory op
    issue(0, 0, 3'd0, 64'h55, 0, 5'd1, e1);
    issue(0, 0, 3'd0, 64'h66, 0, 5'd2, e2);
    check("pass interval", e2 - e1, 2);
    issue(1, 0, 3'd3, 64'h8000_0008, 0, 5'd1, e1);
    issue(1, 0, 3'd3, 64'h8000_0008, 0, 5'd2, e2);
    check("mem interval", e2 - e1, 4);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;

    // Reset in the first ACCESS cycle
    issue(1, 0, 3'd3, 64'h8000_0008, 0, 5'd5, e1);
    check("access started", bus.mem_en, 1);
    rst = 1;
    @(posedge clk); #1;
    check("rst-in-access mem_en",    bus.mem_en,    0);
    check("rst-in-access out_valid", bus.out_valid, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("discarded out_valid", bus.out_valid, 0);
    end
    check("in_ready after access reset", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22041412_lsu.md
YSYX_22041412_LSU -- requirements
Module: ysyx_22041412_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  EX-stage request valid.
REQ-006 in_ready  out  1  LSU can accept a request.
REQ-007 in_is_load, in_is_store  in  1 each  operation kind; both 0 = non-memory pass-through.
REQ-008 in_func3  in  3  RV64 load/store width and sign code.
REQ-009 in_addr  in  ADDR_WIDTH  effective address, or ALU result for pass-through.
REQ-010 in_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-011 in_rd  in  5  destination register.
REQ-012 mem_en, mem_wen  out  1 each  SRAM enable and write enable.
REQ-013 mem_func3  out  3;  mem_addr  out  ADDR_WIDTH;  mem_wdata  out  DATA_WIDTH  registered SRAM request.
REQ-014 mem_stall  in  1;  mem_rdata  in  DATA_WIDTH  SRAM busy and extended read data.
REQ-015 out_valid  out  1;  out_ready  in  1  WB-stage handshake.
REQ-016 out_rd  out  5;  out_data  out  DATA_WIDTH;  out_exc  out  2  (0 none, 1 misaligned, 2 null address, 3 illegal).

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP; in_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a posedge with in_valid & in_ready; all inputs captured into registers at that edge.
REQ-019 Exception check at accept: misaligned = addr[0] for func3 x01, addr[1:0] for x10, addr[2:0] for 011; null = memory op with addr==0; illegal = load & store both set, load func3==111, or store func3>011.
REQ-020 Priority SHALL be illegal > null > misaligned.
REQ-021 Pass-through or any exception: IDLE->RESP; out_data = in_addr for pass-through, 0 for exceptions; mem_en never asserted.
REQ-022 Legal memory op: IDLE->ACCESS; mem_en=1, mem_wen=store, mem_addr/mem_func3/mem_wdata held constant throughout ACCESS.
REQ-023 In ACCESS, the first cycle with mem_stall==0 SHALL capture mem_rdata (loads) or 0 (stores) into out_data and go to RESP; mem_en SHALL be 0 from the following cycle.
REQ-024 A legal access SHALL assert mem_en for exactly 2 cycles against a 1-cycle-stall SRAM; accept-edge to out_valid SHALL be 3 cycles.
REQ-025 RESP: out_valid=1, out_rd/out_data/out_exc stable; out_valid & out_ready -> IDLE.
REQ-026 out_valid SHALL NOT drop without a handshake; mem_en SHALL be 0 in IDLE and RESP.
REQ-027 Store to rd: out_rd SHALL be 0 for stores.
REQ-028 No back-to-back acceptance: minimum issue interval 2 cycles for pass-through and 4 for memory ops.

Reset
REQ-029 rst SHALL force IDLE, and zero in_ready-related state, mem_en, mem_wen, mem_addr, mem_wdata, mem_func3, out_valid, out_rd, out_data and out_exc.
REQ-030 in_ready SHALL be 1 the cycle after reset release.
REQ-031 rst during ACCESS SHALL drop mem_en next cycle; the interrupted result SHALL be discarded and not presented.

Structure
REQ-032 The shared defines package SHALL hold the FSM state encoding, out_exc codes and the zero-word constant.
REQ-033 Combinational legality/alignment check SHALL be sub-module ysyx_22041412_lsu_check (inputs kind, func3, addr[2:0], null flag; output exc).

Verification
REQ-034 ld at 0x80000008 with SRAM returning 0x1122334455667788 -> mem_en 2 cycles, out_valid 3 cycles after accept, out_data 0x1122334455667788, out_exc 0.
REQ-035 lb at 0x80000001 returning 0x80 -> out_data 0xFFFFFFFFFFFFFF80; lbu -> 0x80.
REQ-036 sw at 0x80000002 -> no mem_en, out_exc 1, out_data 0; sd at addr 0 -> out_exc 2.
REQ-037 Pass-through with in_addr 0x1234, out_ready held 0 for 5 cycles -> out_valid and out_data 0x1234 stable until out_ready, in_ready 0 throughout.
REQ-038 rst asserted in first ACCESS cycle -> mem_en 0 next cycle, out_valid never asserts, in_ready 1 after release.
